// File: rtl/debug_stepper_pkg.sv
// debug_stepper_pkg
// Shared definitions for the debug stepper and the pipeline controller that
// consumes its debug_en / debug_step outputs:
//   - command opcodes carried on cmd_op
//   - FSM state encoding (also visible on the stepper's state_dbg port)
//   - the per-state output bundle and the function that decodes it
package debug_stepper_pkg;

    typedef enum logic [1:0] {
        OP_HALT  = 2'd0,
        OP_STEP  = 2'd1,
        OP_STEPN = 2'd2,
        OP_RUN   = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    // Outputs that are a pure function of the FSM state. They are registered
    // together with the state so they change on the same edge.
    typedef struct packed {
        logic debug_en;
        logic debug_step;
        logic cmd_ready;
        logic halted;
    } state_outs_t;

    function automatic state_outs_t state_outs(input state_t s);
        state_outs_t o;
        o = '{debug_en: 1'b1, debug_step: 1'b0, cmd_ready: 1'b1, halted: 1'b1};
        case (s)
            ST_HALT:  o = '{debug_en: 1'b1, debug_step: 1'b0, cmd_ready: 1'b1, halted: 1'b1};
            ST_PULSE: o = '{debug_en: 1'b1, debug_step: 1'b1, cmd_ready: 1'b0, halted: 1'b0};
            ST_GAP:   o = '{debug_en: 1'b1, debug_step: 1'b0, cmd_ready: 1'b0, halted: 1'b0};
            ST_RUN:   o = '{debug_en: 1'b0, debug_step: 1'b0, cmd_ready: 1'b1, halted: 1'b0};
            default:  o = '{debug_en: 1'b1, debug_step: 1'b0, cmd_ready: 1'b1, halted: 1'b1};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/debug_stepper.sv
// debug_stepper
// Debug run-control for the pipeline: halts, single-steps, multi-steps and
// free-runs the pipeline controller, and stops RUN on a PC breakpoint.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   cmd_valid    command offered
//   cmd_op       OP_HALT / OP_STEP / OP_STEPN / OP_RUN
//   cmd_count    step count for OP_STEPN
//   cmd_ready    command slot free (high in HALT and RUN)
//   bp_en        breakpoint enable
//   bp_addr      breakpoint PC
//   pc_id        PC of the instruction in ID
//   id_valid     ID holds a valid instruction
//   debug_en     pipeline suspended when high
//   debug_step   step strobe, pipeline advances one cycle per rising edge
//   halted       high in HALT
//   steps_left   remaining step pulses of the current STEP/STEPN
//   adv_count    number of pipeline-advancing cycles, wraps silently
//   break_hit    one-cycle pulse in the first HALT cycle after a breakpoint
//   state_dbg    current FSM state
//
// Handshake: a command is taken on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready never depends on cmd_valid. Commands
// that have no meaning in the current state are still taken and dropped.
//
// Parameters
//   GAP_CYCLES   low cycles of debug_step after each pulse, 1..15
//   START_HALTED 1: reset into HALT, 0: reset into RUN
//   ADV_INIT     reset value of adv_count (0 in normal use)
module debug_stepper
    import debug_stepper_pkg::*;
#(
    parameter int          GAP_CYCLES   = 1,
    parameter bit          START_HALTED = 1'b1,
    parameter logic [31:0] ADV_INIT     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_count,
    output logic        cmd_ready,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc_id,
    input  logic        id_valid,
    output logic        debug_en,
    output logic        debug_step,
    output logic        halted,
    output logic [7:0]  steps_left,
    output logic [31:0] adv_count,
    output logic        break_hit,
    output logic [1:0]  state_dbg
);

    localparam state_t     RESET_STATE = START_HALTED ? ST_HALT : ST_RUN;
    localparam logic [3:0] GAP_LAST    = 4'(GAP_CYCLES - 1);

    state_t      state_q;
    state_outs_t outs_q;
    logic [3:0]  gap_cnt_q;
    logic [7:0]  steps_left_q;
    logic [31:0] adv_count_q;
    logic        break_hit_q;
    // High during the first RUN cycle after HALT so that resuming from a PC
    // that sits on the breakpoint does not immediately stop again.
    logic        first_run_q;

    logic cmd_fire;
    logic bp_match;

    assign cmd_fire = cmd_valid & outs_q.cmd_ready;
    assign bp_match = bp_en & id_valid & (pc_id == bp_addr) & ~first_run_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RESET_STATE;
            outs_q       <= state_outs(RESET_STATE);
            gap_cnt_q    <= 4'd0;
            steps_left_q <= 8'd0;
            adv_count_q  <= ADV_INIT;
            break_hit_q  <= 1'b0;
            first_run_q  <= 1'b0;
        end else begin
            break_hit_q <= 1'b0;
            case (state_q)
                ST_HALT: begin
                    if (cmd_fire) begin
                        case (cmd_op)
                            OP_STEP: begin
                                state_q      <= ST_PULSE;
                                outs_q       <= state_outs(ST_PULSE);
                                steps_left_q <= 8'd1;
                            end
                            OP_STEPN: begin
                                // A zero count is consumed without a pulse.
                                if (cmd_count != 8'd0) begin
                                    state_q      <= ST_PULSE;
                                    outs_q       <= state_outs(ST_PULSE);
                                    steps_left_q <= cmd_count;
                                end
                            end
                            OP_RUN: begin
                                state_q     <= ST_RUN;
                                outs_q      <= state_outs(ST_RUN);
                                first_run_q <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end

                ST_PULSE: begin
                    // The pipeline advances on this pulse; account for it as
                    // we leave, so steps_left in GAP shows what remains.
                    state_q      <= ST_GAP;
                    outs_q       <= state_outs(ST_GAP);
                    gap_cnt_q    <= 4'd0;
                    steps_left_q <= steps_left_q - 8'd1;
                    adv_count_q  <= adv_count_q + 32'd1;
                end

                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_q <= 4'd0;
                        if (steps_left_q != 8'd0) begin
                            state_q <= ST_PULSE;
                            outs_q  <= state_outs(ST_PULSE);
                        end else begin
                            state_q <= ST_HALT;
                            outs_q  <= state_outs(ST_HALT);
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 4'd1;
                    end
                end

                ST_RUN: begin
                    adv_count_q <= adv_count_q + 32'd1;
                    first_run_q <= 1'b0;
                    // Breakpoint wins over a simultaneous HALT command so the
                    // stop is still reported through break_hit.
                    if (bp_match) begin
                        state_q     <= ST_HALT;
                        outs_q      <= state_outs(ST_HALT);
                        break_hit_q <= 1'b1;
                    end else if (cmd_fire && (cmd_op == OP_HALT)) begin
                        state_q <= ST_HALT;
                        outs_q  <= state_outs(ST_HALT);
                    end
                end

                default: begin
                    state_q      <= ST_HALT;
                    outs_q       <= state_outs(ST_HALT);
                    gap_cnt_q    <= 4'd0;
                    steps_left_q <= 8'd0;
                end
            endcase
        end
    end

    assign debug_en   = outs_q.debug_en;
    assign debug_step = outs_q.debug_step;
    assign cmd_ready  = outs_q.cmd_ready;
    assign halted     = outs_q.halted;
    assign steps_left = steps_left_q;
    assign adv_count  = adv_count_q;
    assign break_hit  = break_hit_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_debug_stepper.sv
// tb_debug_stepper
// Directed bench for debug_stepper. Instance dut (GAP_CYCLES=2, START_HALTED=1)
// is driven from a table of {inputs, expected outputs} records, one record
// per clock. Instance dut_run (START_HALTED=0, adv_count reset near the top)
// covers reset into RUN and adv_count wrap.
module tb_debug_stepper;
    import debug_stepper_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- dut signals ----------------
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [7:0]  cmd_count = 8'd0;
    logic        cmd_ready;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'h0000_0040;
    logic [31:0] pc_id = 32'h0;
    logic        id_valid = 1'b0;
    logic        debug_en, debug_step, halted, break_hit;
    logic [7:0]  steps_left;
    logic [31:0] adv_count;
    logic [1:0]  state_dbg;

    debug_stepper #(.GAP_CYCLES(2), .START_HALTED(1'b1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_count(cmd_count), .cmd_ready(cmd_ready), .bp_en(bp_en),
        .bp_addr(bp_addr), .pc_id(pc_id), .id_valid(id_valid),
        .debug_en(debug_en), .debug_step(debug_step), .halted(halted),
        .steps_left(steps_left), .adv_count(adv_count),
        .break_hit(break_hit), .state_dbg(state_dbg)
    );

    // ---------------- second instance: reset into RUN ----------------
    logic        rst2 = 1'b1;
    logic        cmd_valid2 = 1'b0;
    logic        cmd_ready2;
    logic        debug_en2, debug_step2, halted2, break_hit2;
    logic [7:0]  steps_left2;
    logic [31:0] adv_count2;
    logic [1:0]  state_dbg2;
    logic [1:0]  idle_op = 2'd0;
    logic [7:0]  idle_cnt = 8'd0;
    logic        idle_bp = 1'b0;
    logic [31:0] idle_pc = 32'h0;
    logic        idle_idv = 1'b0;

    debug_stepper #(.GAP_CYCLES(1), .START_HALTED(1'b0), .ADV_INIT(32'hFFFF_FFFE)) dut_run (
        .clk(clk), .rst(rst2), .cmd_valid(cmd_valid2), .cmd_op(idle_op),
        .cmd_count(idle_cnt), .cmd_ready(cmd_ready2), .bp_en(idle_bp),
        .bp_addr(bp_addr), .pc_id(idle_pc), .id_valid(idle_idv),
        .debug_en(debug_en2), .debug_step(debug_step2), .halted(halted2),
        .steps_left(steps_left2), .adv_count(adv_count2),
        .break_hit(break_hit2), .state_dbg(state_dbg2)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", nm, idx, act, exp);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        cv;
        logic [1:0]  op;
        logic [7:0]  cnt;
        logic        bpen;
        logic [31:0] pc;
        logic        idv;
        logic        en;
        logic        st;
        logic        rdy;
        logic        hlt;
        logic [7:0]  sl;
        logic [31:0] adv;
        logic        bh;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mv(
        input logic rst_i, input logic cv, input logic [1:0] op, input logic [7:0] cnt,
        input logic bpen, input logic [31:0] pc, input logic idv,
        input logic en, input logic st, input logic rdy, input logic hlt,
        input logic [7:0] sl, input logic [31:0] adv, input logic bh);
        vec_t v;
        v.rst = rst_i; v.cv = cv; v.op = op; v.cnt = cnt; v.bpen = bpen; v.pc = pc; v.idv = idv;
        v.en = en; v.st = st; v.rdy = rdy; v.hlt = hlt; v.sl = sl; v.adv = adv; v.bh = bh;
        return v;
    endfunction

    // Expected outputs of the HALT / RUN states with given adv_count.
    function automatic vec_t halt_v(input logic rst_i, input logic cv, input logic [1:0] op,
                                    input logic [7:0] cnt, input logic bpen, input logic [31:0] pc,
                                    input logic idv, input logic [31:0] adv, input logic bh);
        return mv(rst_i, cv, op, cnt, bpen, pc, idv, 1, 0, 1, 1, 8'd0, adv, bh);
    endfunction

    function automatic vec_t run_v(input logic cv, input logic [1:0] op, input logic bpen,
                                   input logic [31:0] pc, input logic idv, input logic [31:0] adv);
        return mv(0, cv, op, 8'd0, bpen, pc, idv, 0, 0, 1, 0, 8'd0, adv, 0);
    endfunction

    logic prev_step;

    initial begin
        // reset, idle
        vecs.push_back(halt_v(1, 0, OP_HALT, 0, 0, 0, 0, 0, 0));
        vecs.push_back(halt_v(1, 0, OP_HALT, 0, 0, 0, 0, 0, 0));
        vecs.push_back(halt_v(0, 0, OP_HALT, 0, 0, 0, 0, 0, 0));
        // single STEP, GAP of 2, a RUN offered while busy is not taken
        vecs.push_back(mv(0, 1, OP_STEP, 0, 0, 0, 0, 1, 1, 0, 0, 8'd1, 0, 0));
        vecs.push_back(mv(0, 1, OP_RUN,  0, 0, 0, 0, 1, 0, 0, 0, 8'd0, 1, 0));
        vecs.push_back(mv(0, 0, OP_HALT, 0, 0, 0, 0, 1, 0, 0, 0, 8'd0, 1, 0));
        vecs.push_back(halt_v(0, 0, OP_HALT, 0, 0, 0, 0, 1, 0));
        // STEPN 0 is consumed with no pulse
        vecs.push_back(halt_v(0, 1, OP_STEPN, 0, 0, 0, 0, 1, 0));
        // STEPN 3: pulses 3 cycles apart, steps_left counts down
        vecs.push_back(mv(0, 1, OP_STEPN, 3, 0, 0, 0, 1, 1, 0, 0, 8'd3, 1, 0));
        vecs.push_back(mv(0, 0, OP_HALT, 0, 0, 0, 0, 1, 0, 0, 0, 8'd2, 2, 0));
        vecs.push_back(mv(0, 0, OP_HALT, 0, 0, 0, 0, 1, 0, 0, 0, 8'd2, 2, 0));
        vecs.push_back(mv(0, 0, OP_HALT, 0, 0, 0, 0, 1, 1, 0, 0, 8'd2, 2, 0));
        vecs.push_back(mv(0, 0, OP_HALT, 0, 0, 0, 0, 1, 0, 0, 0, 8'd1, 3, 0));
        vecs.push_back(mv(0, 0, OP_HALT, 0, 0, 0, 0, 1, 0, 0, 0, 8'd1, 3, 0));
        vecs.push_back(mv(0, 0, OP_HALT, 0, 1, 32'h40, 1, 1, 1, 0, 0, 8'd1, 3, 0));
        vecs.push_back(mv(0, 0, OP_HALT, 0, 1, 32'h40, 1, 1, 0, 0, 0, 8'd0, 4, 0));
        vecs.push_back(mv(0, 0, OP_HALT, 0, 1, 32'h40, 1, 1, 0, 0, 0, 8'd0, 4, 0));
        vecs.push_back(halt_v(0, 0, OP_HALT, 0, 1, 32'h40, 1, 4, 0));
        // breakpoint ignored in HALT
        vecs.push_back(halt_v(0, 0, OP_HALT, 0, 1, 32'h40, 1, 4, 0));
        // RUN while sitting on the breakpoint: no immediate re-break
        vecs.push_back(run_v(1, OP_RUN,  1, 32'h40, 1, 4));
        vecs.push_back(run_v(0, OP_HALT, 1, 32'h40, 1, 5));
        vecs.push_back(run_v(0, OP_HALT, 1, 32'h44, 1, 6));
        vecs.push_back(run_v(0, OP_HALT, 1, 32'h48, 1, 7));
        // match without id_valid, then match with bp_en low: no stop
        vecs.push_back(run_v(0, OP_HALT, 1, 32'h40, 0, 8));
        vecs.push_back(run_v(0, OP_HALT, 0, 32'h40, 1, 9));
        // real breakpoint hit, break_hit for one cycle only
        vecs.push_back(halt_v(0, 0, OP_HALT, 0, 1, 32'h40, 1, 10, 1));
        vecs.push_back(halt_v(0, 0, OP_HALT, 0, 1, 32'h40, 1, 10, 0));
        // STEP / STEPN / RUN are dropped in RUN, HALT stops it
        vecs.push_back(run_v(1, OP_RUN,   1, 32'h0, 1, 10));
        vecs.push_back(run_v(1, OP_STEP,  1, 32'h0, 1, 11));
        vecs.push_back(run_v(1, OP_STEPN, 1, 32'h0, 1, 12));
        vecs.push_back(run_v(1, OP_RUN,   1, 32'h0, 1, 13));
        vecs.push_back(halt_v(0, 1, OP_HALT, 0, 1, 32'h0, 1, 14, 0));
        // breakpoint and HALT command together
        vecs.push_back(run_v(1, OP_RUN,  1, 32'h0, 1, 14));
        vecs.push_back(run_v(0, OP_HALT, 1, 32'h0, 1, 15));
        vecs.push_back(halt_v(0, 1, OP_HALT, 0, 1, 32'h40, 1, 16, 1));
        // reset during the GAP of STEPN 5
        vecs.push_back(mv(0, 1, OP_STEPN, 5, 0, 0, 0, 1, 1, 0, 0, 8'd5, 16, 0));
        vecs.push_back(mv(0, 0, OP_HALT, 0, 0, 0, 0, 1, 0, 0, 0, 8'd4, 17, 0));
        vecs.push_back(halt_v(1, 0, OP_HALT, 0, 0, 0, 0, 0, 0));
        vecs.push_back(halt_v(0, 0, OP_HALT, 0, 0, 0, 0, 0, 0));
        vecs.push_back(halt_v(0, 0, OP_HALT, 0, 0, 0, 0, 0, 0));

        prev_step = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            rst       = vecs[i].rst;
            cmd_valid = vecs[i].cv;
            cmd_op    = vecs[i].op;
            cmd_count = vecs[i].cnt;
            bp_en     = vecs[i].bpen;
            pc_id     = vecs[i].pc;
            id_valid  = vecs[i].idv;
            @(posedge clk);
            #1;
            chk("debug_en",   i, 32'(debug_en),   32'(vecs[i].en));
            chk("debug_step", i, 32'(debug_step), 32'(vecs[i].st));
            chk("cmd_ready",  i, 32'(cmd_ready),  32'(vecs[i].rdy));
            chk("halted",     i, 32'(halted),     32'(vecs[i].hlt));
            chk("steps_left", i, 32'(steps_left), 32'(vecs[i].sl));
            chk("adv_count",  i, adv_count,       vecs[i].adv);
            chk("break_hit",  i, 32'(break_hit),  32'(vecs[i].bh));
            // debug_step must not stay high across consecutive cycles
            chk("step_back_to_back", i, 32'(prev_step & debug_step), 32'd0);
            prev_step = debug_step;
        end

        // ---------------- dut_run: reset into RUN and counter wrap ----------------
        @(posedge clk);
        #1;
        chk("run_rst_debug_en",  100, 32'(debug_en2),  32'd0);
        chk("run_rst_halted",    100, 32'(halted2),    32'd0);
        chk("run_rst_cmd_ready", 100, 32'(cmd_ready2), 32'd1);
        chk("run_rst_step",      100, 32'(debug_step2), 32'd0);
        chk("run_rst_steps",     100, 32'(steps_left2), 32'd0);
        chk("run_rst_break",     100, 32'(break_hit2), 32'd0);
        chk("run_rst_adv",       100, adv_count2,      32'hFFFF_FFFE);
        rst2 = 1'b0;
        @(posedge clk); #1;
        chk("wrap_adv_1", 101, adv_count2, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        chk("wrap_adv_2", 102, adv_count2, 32'h0000_0000);
        @(posedge clk); #1;
        chk("wrap_adv_3", 103, adv_count2, 32'h0000_0001);
        chk("wrap_still_run", 103, 32'(debug_en2), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/debug_stepper.md
DEBUG_STEPPER -- requirements
Module: debug_stepper

Interface
REQ-001 Parameter GAP_CYCLES, default 1, SHALL set the number of low cycles of debug_step after each step pulse; legal range 1..15.
REQ-002 Parameter START_HALTED, default 1, SHALL select the state after reset: 1 = HALT, 0 = RUN.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_op  input  2  command: 0 HALT, 1 STEP, 2 STEPN, 3 RUN.
REQ-007 cmd_count  input  8  number of steps for STEPN.
REQ-008 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-009 bp_en  input  1  breakpoint enable.
REQ-010 bp_addr  input  32  breakpoint PC.
REQ-011 pc_id  input  32  PC of the instruction in the ID stage.
REQ-012 id_valid  input  1  ID stage holds a valid instruction.
REQ-013 debug_en  output  1  suspends the pipeline when high; drives the pipeline controller's debug_en.
REQ-014 debug_step  output  1  step strobe; the controller advances one cycle on each rising edge.
REQ-015 halted  output  1  high in state HALT.
REQ-016 steps_left  output  8  remaining STEPN pulses.
REQ-017 adv_count  output  32  count of pipeline-advancing cycles.
REQ-018 break_hit  output  1  one-cycle pulse when a breakpoint stops RUN.

Function
REQ-019 FSM states SHALL be HALT, PULSE, GAP and RUN, and all outputs SHALL be registered.
REQ-020 HALT SHALL drive debug_en=1, debug_step=0, cmd_ready=1.
REQ-021 HALT on STEP SHALL go to PULSE with steps_left=1.
REQ-022 HALT on STEPN with cmd_count>0 SHALL go to PULSE with steps_left=cmd_count.
REQ-023 HALT on STEPN with cmd_count=0 SHALL stay in HALT; the command is consumed with no pulse.
REQ-024 HALT on RUN SHALL go to RUN; HALT on a HALT command is a no-op.
REQ-025 PULSE SHALL last exactly 1 cycle with debug_en=1, debug_step=1, cmd_ready=0, and SHALL decrement steps_left and adv_count+1.
REQ-026 GAP SHALL last GAP_CYCLES cycles with debug_step=0, debug_en=1, cmd_ready=0.
REQ-027 At GAP end, steps_left>0 SHALL return to PULSE and steps_left=0 SHALL go to HALT.
REQ-028 debug_step SHALL never be high on two consecutive cycles.
REQ-029 RUN SHALL drive debug_en=0, debug_step=0, cmd_ready=1, and adv_count+1 every cycle.
REQ-030 RUN on a HALT command SHALL go to HALT on the next cycle; STEP, STEPN and RUN SHALL be consumed and ignored.
REQ-031 Breakpoint: in RUN, bp_en and id_valid and pc_id==bp_addr SHALL go to HALT next cycle with break_hit=1 for that one cycle, and debug_en=1 from that cycle on.
REQ-032 A breakpoint SHALL be checked only in RUN; in HALT, PULSE and GAP it is ignored.
REQ-033 A breakpoint and a HALT command in the same RUN cycle SHALL go to HALT with break_hit=1.
REQ-034 Breakpoint re-arm: the first RUN cycle after leaving HALT SHALL ignore a breakpoint match so a stopped-at PC can resume.
REQ-035 adv_count SHALL wrap from 0xFFFFFFFF to 0 with no saturation and no flag.
REQ-036 steps_left SHALL be 0 in HALT and RUN.

Reset
REQ-037 rst SHALL take priority over all commands and events, including mid-PULSE or mid-GAP; the pending steps are discarded.
REQ-038 Reset values SHALL be:
- state HALT if START_HALTED=1, else RUN;
- debug_en equal to START_HALTED;
- debug_step=0, steps_left=0, adv_count=0, break_hit=0, gap counter=0;
- cmd_ready=1, halted equal to START_HALTED.

Structure
REQ-039 Command opcodes and FSM state encodings SHALL live in the shared define header used by the pipeline controller.
REQ-040 The block SHALL be a single module with no sub-module; the GAP counter is 4 bits, inline.

Verification
REQ-041 Reset with START_HALTED=1, then STEP -> exactly one debug_step high cycle, then HALT; adv_count=1.
REQ-042 STEPN count=3, GAP_CYCLES=2 -> pulses spaced 3 cycles apart, steps_left 3→2→1→0, then HALT; cmd_ready=0 throughout.
REQ-043 RUN with bp_en=1, bp_addr=0x40, and pc_id reaching 0x40 with id_valid=1 -> HALT next cycle, break_hit=1 for 1 cycle, debug_en=1.
REQ-044 RUN from HALT while pc_id=bp_addr -> no immediate re-break; a later match does stop execution.
REQ-045 rst asserted during GAP of STEPN 5 -> HALT next cycle with steps_left=0 and no further pulses.
REQ-046 adv_count preloaded near 0xFFFFFFFE, RUN for 3 cycles -> value 0x00000001.
